riscv_trace_buffer: RTL and testbench
=====================================

Name: riscv_trace_buffer

Overview:
- Synthesizable commit-trace capture block for the RISC-V core. Takes over the per-cycle PC/instruction/ALU-result reporting that currently exists only as bench printouts.
- Records retired-instruction tuples into a parametrised circular buffer. Arms, fires on a programmable opcode trigger, captures a programmable number of post-trigger entries, then freezes.
- Frozen contents are read out oldest-first over a valid/ready port.
- Sits beside the core top level, fed by its pc, instruction and alu_out nets.

Parameters:
- XLEN, 32, width of the pc, instruction and result fields.
- DEPTH_LOG2, 4, log2 of the buffer entry count (DEPTH = 2**DEPTH_LOG2, minimum 2).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- trace_valid  in  1  one instruction retires this cycle.
- trace_pc  in  XLEN  PC of the retiring instruction.
- trace_instr  in  XLEN  retiring instruction word.
- trace_result  in  XLEN  ALU output of the retiring instruction.
- arm  in  1  single-cycle start-capture pulse.
- disarm  in  1  abort; return to IDLE.
- trig_en  in  1  enable the opcode trigger.
- trig_opcode  in  7  opcode compared against trace_instr[6:0].
- post_count  in  DEPTH_LOG2  number of entries captured after the trigger entry.
- rd_ready  in  1  consumer accepts the current read entry.
- rd_valid  out  1  read entry present.
- rd_pc, rd_instr, rd_result  out  XLEN each  oldest unread entry.
- state  out  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE.
- count  out  DEPTH_LOG2+1  valid entries held.
- wrapped  out  1  at least one entry was overwritten during ARMED.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; count=0; wr_ptr=0; rd_ptr=0; post_left=0; wrapped=0; rd_valid=0. Buffer RAM is not reset.
- IDLE: nothing is written. arm -> ARMED, clearing count, wr_ptr and wrapped.
- ARMED:
  - Each trace_valid writes {pc, instr, result} at wr_ptr; wr_ptr increments modulo DEPTH.
  - count saturates at DEPTH. A write while count==DEPTH sets wrapped (sticky until the next arm).
  - Trigger = trace_valid & trig_en & (trace_instr[6:0]==trig_opcode). The triggering entry is always written.
  - On trigger: if post_count==0 -> DONE, otherwise -> POST with post_left=post_count.
  - With trig_en=0, the block stays in ARMED indefinitely.
- POST:
  - Each trace_valid writes one entry and decrements post_left.
  - The write that brings post_left to 0 moves the state to DEPTH DONE on the same edge.
  - Further trigger matches are ignored.
  - post_count is sampled only at the trigger edge.
- DONE:
  - Writing stops. On DONE entry, rd_ptr = wr_ptr - count (modulo DEPTH), i.e. the oldest entry.
  - rd_valid = (count != 0). rd_* are combinational from the entry at rd_ptr.
  - A cycle with rd_valid & rd_ready advances rd_ptr and decrements count.
  - When count reaches 0 -> IDLE.
  - Read latency: the first entry is valid in the first cycle of DONE.
- disarm in any state: -> IDLE, count=0, rd_valid=0 on the next edge.
- Priority when pulses coincide: disarm > arm > trigger/read.
  - arm in DONE restarts capture and discards unread entries.
  - arm in ARMED or POST is ignored.
- count never exceeds DEPTH. Entries overwritten in ARMED are lost; readout starts at the oldest surviving entry.
- No trace_valid cycles in POST: the block stays in POST indefinitely.

Optional Feature:
- Macro: RISCV_TRACE_TIMESTAMP_EN.
- When defined:
  - A 32-bit free-running cycle counter is added, cleared by reset and wrapping at 2**32.
  - Its value is stored with each entry.
  - Extra output port rd_timestamp (out, 32) presents it alongside rd_pc.
- When undefined: the counter, the extra storage and the rd_timestamp port are absent. All other behaviour is identical.

Test Plan:
- Reset mid-POST: assert reset low asynchronously -> state=00, count=0, rd_valid=0 before the next clk edge.
- DEPTH_LOG2=4, trig_opcode=7'b0000011, post_count=2: 5 ADDIs, then LW at pc 0x14, then 2 ADDIs -> DONE, count=8, wrapped=0; readout pc order 0x00..0x1C, with the LW at entry 5.
- ARMED with 20 writes, then trigger with post_count=0 -> count=16, wrapped=1; first rd_pc is the pc of write #6 (1-based); last entry is the trigger.
- trig_en=0, 40 instructions -> state stays 01, count=16; then disarm -> state=00, count=0.
- DONE with 3 entries, rd_ready held low 4 cycles, then high -> rd_pc stable while stalled; one entry per cycle afterwards; IDLE after the 3rd accept.
- arm and disarm asserted in the same cycle in DONE -> IDLE, count=0. With RISCV_TRACE_TIMESTAMP_EN defined: timestamps of consecutive back-to-back entries differ by exactly 1.

Source files
------------

// File: rtl/riscv_trace_buffer.sv
// rtl/riscv_trace_buffer.sv - commit-trace capture buffer with opcode trigger and oldest-first readout.
// Optional per-entry cycle timestamp when RISCV_TRACE_TIMESTAMP_EN is defined.
module riscv_trace_buffer #(
  parameter int XLEN       = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trace_valid,
  input  logic [XLEN-1:0]       trace_pc,
  input  logic [XLEN-1:0]       trace_instr,
  input  logic [XLEN-1:0]       trace_result,
  input  logic                  arm,
  input  logic                  disarm,
  input  logic                  trig_en,
  input  logic [6:0]            trig_opcode,
  input  logic [DEPTH_LOG2-1:0] post_count,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [XLEN-1:0]       rd_pc,
  output logic [XLEN-1:0]       rd_instr,
  output logic [XLEN-1:0]       rd_result,
  output logic [1:0]            state,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  wrapped
`ifdef RISCV_TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]           rd_timestamp
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] post_left_q, post_left_d;
  logic                  wrapped_q, wrapped_d;
  logic                  we;
  logic                  trig;
  logic [DEPTH_LOG2-1:0] wr_inc;
  logic [DEPTH_LOG2:0]   cnt_inc;

  logic [XLEN-1:0] pc_mem     [DEPTH];
  logic [XLEN-1:0] instr_mem  [DEPTH];
  logic [XLEN-1:0] result_mem [DEPTH];

  assign trig    = trace_valid & trig_en & (trace_instr[6:0] == trig_opcode);
  assign wr_inc  = wr_ptr_q + 1'b1;
  assign cnt_inc = (count_q == FULL) ? count_q : count_q + 1'b1;

  assign rd_valid  = (state_q == S_DONE) && (count_q != '0);
  assign rd_pc     = pc_mem[rd_ptr_q];
  assign rd_instr  = instr_mem[rd_ptr_q];
  assign rd_result = result_mem[rd_ptr_q];
  assign state     = state_q;
  assign count     = count_q;
  assign wrapped   = wrapped_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    post_left_d = post_left_q;
    wrapped_d   = wrapped_q;
    we          = 1'b0;
    if (disarm) begin
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d   = S_ARMED;
            count_d   = '0;
            wr_ptr_d  = '0;
            wrapped_d = 1'b0;
          end
        end
        S_ARMED: begin
          if (trace_valid) begin
            we       = 1'b1;
            wr_ptr_d = wr_inc;
            count_d  = cnt_inc;
            if (count_q == FULL) wrapped_d = 1'b1;
            if (trig) begin
              if (post_count == '0) begin
                state_d  = S_DONE;
                rd_ptr_d = wr_inc - cnt_inc[DEPTH_LOG2-1:0];
              end else begin
                state_d     = S_POST;
                post_left_d = post_count;
              end
            end
          end
        end
        S_POST: begin
          if (trace_valid) begin
            we          = 1'b1;
            wr_ptr_d    = wr_inc;
            count_d     = cnt_inc;
            post_left_d = post_left_q - 1'b1;
            if (post_left_q == DEPTH_LOG2'(1)) begin
              state_d  = S_DONE;
              rd_ptr_d = wr_inc - cnt_inc[DEPTH_LOG2-1:0];
            end
          end
        end
        S_DONE: begin
          // A re-arm throws away whatever has not been read yet.
          if (arm) begin
            state_d   = S_ARMED;
            count_d   = '0;
            wr_ptr_d  = '0;
            wrapped_d = 1'b0;
          end else if (count_q == '0) begin
            state_d = S_IDLE;
          end else if (rd_ready) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
            if (count_q == CW'(1)) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      post_left_q <= '0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      post_left_q <= post_left_d;
      wrapped_q   <= wrapped_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      pc_mem[wr_ptr_q]     <= trace_pc;
      instr_mem[wr_ptr_q]  <= trace_instr;
      result_mem[wr_ptr_q] <= trace_result;
    end
  end

`ifdef RISCV_TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] ts_mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (we) ts_mem[wr_ptr_q] <= ts_q;
  end

  assign rd_timestamp = ts_mem[rd_ptr_q];
`endif

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// tb/tb_riscv_trace_buffer.sv - directed table and sequence checks for riscv_trace_buffer.
// Define RISCV_TRACE_TIMESTAMP_EN to also check per-entry timestamps.
module tb_riscv_trace_buffer;

  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] LW   = 32'h0000_2003;

  logic        clk;
  logic        reset;
  logic        trace_valid;
  logic [31:0] trace_pc, trace_instr, trace_result;
  logic        arm, disarm, trig_en;
  logic [6:0]  trig_opcode;
  logic [3:0]  post_count;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_pc, rd_instr, rd_result;
  logic [1:0]  state;
  logic [4:0]  count;
  logic        wrapped;
`ifdef RISCV_TRACE_TIMESTAMP_EN
  logic [31:0] rd_timestamp;
  logic [31:0] ts_prev;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  riscv_trace_buffer #(.XLEN(32), .DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_instr(trace_instr), .trace_result(trace_result), .arm(arm), .disarm(disarm),
    .trig_en(trig_en), .trig_opcode(trig_opcode), .post_count(post_count),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .rd_result(rd_result), .state(state), .count(count), .wrapped(wrapped)
`ifdef RISCV_TRACE_TIMESTAMP_EN
    , .rd_timestamp(rd_timestamp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        a;
    logic        rdy;
    logic [1:0]  st;
    logic [4:0]  cnt;
    logic        rv;
    logic [31:0] epc;
    logic [31:0] einstr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [31:0] pc, logic [31:0] instr, logic a,
                              logic rdy, logic [1:0] st, logic [4:0] cnt, logic rv,
                              logic [31:0] epc, logic [31:0] einstr);
    vec_t r;
    r.v = v; r.pc = pc; r.instr = instr; r.a = a; r.rdy = rdy;
    r.st = st; r.cnt = cnt; r.rv = rv; r.epc = epc; r.einstr = einstr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic a, input logic d, input logic te, input logic [3:0] pcnt,
                       input logic rdy);
    trace_valid  = v;
    trace_pc     = pc;
    trace_instr  = instr;
    trace_result = pc + 32'h100;
    arm          = a;
    disarm       = d;
    trig_en      = te;
    post_count   = pcnt;
    rd_ready     = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, ADDI, 1'b0, 1'b0, 1'b1, 4'd0, rdy);
  endtask

  task automatic chk_status(input string name, input logic [1:0] st, input logic [4:0] cnt,
                            input logic rv);
    chk({name, ".state"}, 64'(state), 64'(st));
    chk({name, ".count"}, 64'(count), 64'(cnt));
    chk({name, ".rd_valid"}, 64'(rd_valid), 64'(rv));
  endtask

  initial begin
    trig_opcode = 7'b0000011;
    idle(1'b0);
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk_status("reset", 2'b00, 5'd0, 1'b0);
    chk("reset.wrapped", 64'(wrapped), 64'd0);
    #9 reset = 1'b1;
    tick();

    // Scenario: 5 ADDIs, LW trigger at 0x14, two post entries, full readout.
    tbl.push_back(mk(1'b0, 32'h0, ADDI, 1'b1, 1'b0, 2'b01, 5'd0, 1'b0, 32'h0, 32'h0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1'b1, 32'(4 * i), ADDI, 1'b0, 1'b0, 2'b01, 5'(i + 1), 1'b0, 32'h0, 32'h0));
    tbl.push_back(mk(1'b1, 32'h14, LW,   1'b0, 1'b0, 2'b10, 5'd6, 1'b0, 32'h0, 32'h0));
    tbl.push_back(mk(1'b1, 32'h18, ADDI, 1'b0, 1'b0, 2'b10, 5'd7, 1'b0, 32'h0, 32'h0));
    tbl.push_back(mk(1'b1, 32'h1C, ADDI, 1'b0, 1'b0, 2'b11, 5'd8, 1'b1, 32'h0, ADDI));
    for (int k = 1; k <= 8; k++) begin
      if (k < 8)
        tbl.push_back(mk(1'b0, 32'h0, ADDI, 1'b0, 1'b1, 2'b11, 5'(8 - k), 1'b1,
                         32'(4 * k), (k == 5) ? LW : ADDI));
      else
        tbl.push_back(mk(1'b0, 32'h0, ADDI, 1'b0, 1'b1, 2'b00, 5'd0, 1'b0, 32'h0, 32'h0));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].pc, tbl[i].instr, tbl[i].a, 1'b0, 1'b1, 4'd2, tbl[i].rdy);
      tick();
      chk_status($sformatf("tbl%0d", i), tbl[i].st, tbl[i].cnt, tbl[i].rv);
      chk($sformatf("tbl%0d.wrapped", i), 64'(wrapped), 64'd0);
      if (tbl[i].rv) begin
        chk($sformatf("tbl%0d.rd_pc", i), 64'(rd_pc), 64'(tbl[i].epc));
        chk($sformatf("tbl%0d.rd_instr", i), 64'(rd_instr), 64'(tbl[i].einstr));
        chk($sformatf("tbl%0d.rd_result", i), 64'(rd_result), 64'(tbl[i].epc + 32'h100));
      end
    end

    // Wrap: 20 writes then a post_count=0 trigger keeps writes 6..21.
    drive(1'b0, 32'h0, ADDI, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
    tick();
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 32'(4 * (i - 1)), ADDI, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h50, LW, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    tick();
    chk_status("wrap", 2'b11, 5'd16, 1'b1);
    chk("wrap.wrapped", 64'(wrapped), 64'd1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("wrap.rd_pc%0d", k), 64'(rd_pc), 64'(32'h14 + 32'(4 * k)));
      if (k == 15) chk("wrap.last_instr", 64'(rd_instr), 64'(LW));
      idle(1'b1);
      tick();
    end
    chk_status("wrap.end", 2'b00, 5'd0, 1'b0);

    // No trigger: stays ARMED and saturates, then disarm.
    drive(1'b0, 32'h0, ADDI, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 32'(4 * i), (i % 2 == 0) ? LW : ADDI, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      tick();
    end
    chk_status("notrig", 2'b01, 5'd16, 1'b0);
    chk("notrig.wrapped", 64'(wrapped), 64'd1);
    drive(1'b0, 32'h0, ADDI, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    tick();
    chk_status("disarm", 2'b00, 5'd0, 1'b0);

    // Readout stall: three entries, consumer holds off four cycles.
    drive(1'b0, 32'h0, ADDI, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0);
    tick();
    chk("rearm.wrapped", 64'(wrapped), 64'd0);
    drive(1'b1, 32'h200, LW, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
    tick();
    drive(1'b1, 32'h204, ADDI, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
    tick();
    drive(1'b1, 32'h208, ADDI, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
    tick();
    chk_status("stall.done", 2'b11, 5'd3, 1'b1);
    idle(1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("stall.rd_pc%0d", c), 64'(rd_pc), 64'h200);
      chk($sformatf("stall.count%0d", c), 64'(count), 64'd3);
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("drain.rd_pc%0d", k), 64'(rd_pc), 64'(32'h200 + 32'(4 * k)));
`ifdef RISCV_TRACE_TIMESTAMP_EN
      if (k > 0) chk($sformatf("drain.ts_delta%0d", k), 64'(rd_timestamp - ts_prev), 64'd1);
      ts_prev = rd_timestamp;
`endif
      idle(1'b1);
      tick();
    end
    chk_status("drain.end", 2'b00, 5'd0, 1'b0);

    // arm+disarm together in DONE: disarm wins.
    drive(1'b0, 32'h0, ADDI, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
    tick();
    drive(1'b1, 32'h300, LW, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    tick();
    chk_status("ad.done", 2'b11, 5'd1, 1'b1);
    drive(1'b0, 32'h0, ADDI, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0);
    tick();
    chk_status("ad.idle", 2'b00, 5'd0, 1'b0);

    // arm alone in DONE restarts capture.
    drive(1'b0, 32'h0, ADDI, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
    tick();
    drive(1'b1, 32'h400, LW, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    tick();
    drive(1'b0, 32'h0, ADDI, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
    tick();
    chk_status("rearm.done", 2'b01, 5'd0, 1'b0);

    // Asynchronous reset while in POST.
    drive(1'b1, 32'h500, LW, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
    tick();
    drive(1'b1, 32'h504, ADDI, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
    tick();
    chk_status("post", 2'b10, 5'd2, 1'b0);
    idle(1'b0);
    #3 reset = 1'b0;
    #1;
    chk_status("async_reset", 2'b00, 5'd0, 1'b0);
    #2 reset = 1'b1;
    tick();
    chk_status("after_reset", 2'b00, 5'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
